// File: rtl/mrd_iter_engine.sv
// Iterative refinement engine: x <- x + M*(b - A*x) in signed fixed point,
// one matrix row per cycle, stopping early on an all-zero residual pass.

module mrd_iter_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          v,
  output logic signed [2*WIDTH-1:0] p
);
  assign p = $signed(a) * $signed(v);
endmodule

module mrd_iter_engine #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int FRAC      = 4,
  parameter int ITER_W    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ITER_W-1:0]                num_iter,
  input  logic [DIMENSION*DIMENSION*WIDTH-1:0] A,
  input  logic [DIMENSION*DIMENSION*WIDTH-1:0] M,
  input  logic [DIMENSION*WIDTH-1:0]       b,
  input  logic [DIMENSION*WIDTH-1:0]       x0,
  output logic                             busy,
  output logic                             done,
  output logic                             converged,
  output logic [ITER_W-1:0]                iter_used,
  output logic [DIMENSION*WIDTH-1:0]       x_final
);
  localparam int RW    = $clog2(DIMENSION);
  localparam int ACC_W = 2*WIDTH + $clog2(DIMENSION);
  localparam int SW    = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RES, S_UPD, S_DONE} state_t;
  typedef logic [DIMENSION-1:0][WIDTH-1:0] vec_t;
  typedef logic [DIMENSION-1:0][DIMENSION-1:0][WIDTH-1:0] mat_t;

  mat_t a_m, m_m;
  vec_t b_v, x0_v;
  assign a_m  = A;
  assign m_m  = M;
  assign b_v  = b;
  assign x0_v = x0;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ITER_W-1:0] iter_q, iter_d, nit_q, nit_d, iter_used_q, iter_used_d;
  logic              zflag_q, zflag_d, done_q, done_d, conv_q, conv_d, busy_q, busy_d;
  vec_t              x_q, x_d, r_q, r_d, xf_q, xf_d;

  // RES walks rows of A against x; UPD walks rows of M against the frozen r.
  vec_t row_mat, row_vec;
  assign row_mat = (state_q == S_UPD) ? m_m[row_q] : a_m[row_q];
  assign row_vec = (state_q == S_UPD) ? r_q : x_q;

  logic signed [2*WIDTH-1:0] prod [DIMENSION];
  for (genvar g = 0; g < DIMENSION; g++) begin : g_lane
    mrd_iter_lane #(.WIDTH(WIDTH)) u_lane (
      .a(row_mat[g]),
      .v(row_vec[g]),
      .p(prod[g])
    );
  end

  logic signed [ACC_W-1:0] acc, acc_sh;
  always_comb begin
    acc = '0;
    for (int j = 0; j < DIMENSION; j++) acc = acc + ACC_W'(prod[j]);
  end
  assign acc_sh = acc >>> FRAC;

  logic signed [SW-1:0] res_full, upd_full;
  assign res_full = SW'($signed(b_v[row_q])) - SW'(acc_sh);
  assign upd_full = SW'($signed(x_q[row_q])) + SW'(acc_sh);

  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] hi, lo;
    hi = SW'((1 <<< (WIDTH-1)) - 1);
    lo = ~hi;
    if (v > hi)      return hi[WIDTH-1:0];
    else if (v < lo) return lo[WIDTH-1:0];
    else             return v[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]  res_sat, upd_sat;
  logic              last_row, zflag_row;
  logic [ITER_W-1:0] iter_inc;
  assign res_sat   = sat(res_full);
  assign upd_sat   = sat(upd_full);
  assign last_row  = (row_q == RW'(DIMENSION-1));
  assign zflag_row = zflag_q & (res_sat == '0);
  assign iter_inc  = iter_q + ITER_W'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    iter_d      = iter_q;
    nit_d       = nit_q;
    zflag_d     = zflag_q;
    x_d         = x_q;
    r_d         = r_q;
    xf_d        = xf_q;
    conv_d      = conv_q;
    iter_used_d = iter_used_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = x0_v;
        row_d   = '0;
        iter_d  = '0;
        zflag_d = 1'b1;
        nit_d   = num_iter;
        if (num_iter == '0) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          conv_d      = 1'b0;
          iter_used_d = '0;
          xf_d        = x0_v;
        end else begin
          state_d = S_RES;
        end
      end
      S_RES: begin
        r_d[row_q] = res_sat;
        zflag_d    = zflag_row;
        row_d      = row_q + RW'(1);
        if (last_row) begin
          row_d = '0;
          if (zflag_row) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            conv_d      = 1'b1;
            iter_used_d = iter_q;
            xf_d        = x_q;
          end else begin
            state_d = S_UPD;
          end
        end
      end
      S_UPD: begin
        x_d[row_q] = upd_sat;
        row_d      = row_q + RW'(1);
        if (last_row) begin
          row_d  = '0;
          iter_d = iter_inc;
          if (iter_inc == nit_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            conv_d      = 1'b0;
            iter_used_d = iter_inc;
            xf_d        = x_d;
          end else begin
            state_d = S_RES;
            zflag_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      iter_q      <= '0;
      nit_q       <= '0;
      zflag_q     <= 1'b0;
      x_q         <= '0;
      r_q         <= '0;
      xf_q        <= '0;
      conv_q      <= 1'b0;
      iter_used_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      iter_q      <= iter_d;
      nit_q       <= nit_d;
      zflag_q     <= zflag_d;
      x_q         <= x_d;
      r_q         <= r_d;
      xf_q        <= xf_d;
      conv_q      <= conv_d;
      iter_used_q <= iter_used_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign iter_used = iter_used_q;
  assign x_final   = xf_q;
endmodule

// File: tb/tb_mrd_iter_engine.sv
// Randomised bench for mrd_iter_engine against a plain matrix-arithmetic model.
module tb_mrd_iter_engine;
  localparam int D = 16, W = 8, F = 4, IW = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IW-1:0]      num_iter = '0;
  logic [D*D*W-1:0]   A = '0, M = '0;
  logic [D*W-1:0]     b = '0, x0 = '0;
  logic               busy, done, converged;
  logic [IW-1:0]      iter_used;
  logic [D*W-1:0]     x_final;

  mrd_iter_engine #(.DIMENSION(D), .WIDTH(W), .FRAC(F), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter),
    .A(A), .M(M), .b(b), .x0(x0),
    .busy(busy), .done(done), .converged(converged),
    .iter_used(iter_used), .x_final(x_final)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int Am[D][D], Mm[D][D], bv[D], x0v[D];
  logic [D*W-1:0] exp_x, prev_x;
  logic           exp_conv, prev_conv;
  int             exp_it, exp_cyc, prev_it;

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int rs(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic chk(input string name, input logic [D*W-1:0] got, input logic [D*W-1:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Reference solve in plain integer arithmetic.
  task automatic model(input int n);
    int x[D], r[D];
    int acc, it;
    bit fin, z;
    for (int i = 0; i < D; i++) x[i] = x0v[i];
    it = 0; exp_conv = 1'b0; fin = (n == 0);
    while (!fin) begin
      z = 1'b1;
      for (int i = 0; i < D; i++) begin
        acc = 0;
        for (int j = 0; j < D; j++) acc += Am[i][j] * x[j];
        r[i] = sat(bv[i] - (acc >>> F));
        if (r[i] != 0) z = 1'b0;
      end
      if (z) begin
        exp_conv = 1'b1; fin = 1'b1;
      end else begin
        for (int i = 0; i < D; i++) begin
          acc = 0;
          for (int j = 0; j < D; j++) acc += Mm[i][j] * r[j];
          x[i] = sat(x[i] + (acc >>> F));
        end
        it++;
        if (it == n) fin = 1'b1;
      end
    end
    exp_it  = it;
    exp_cyc = (n == 0) ? 1 : exp_conv ? 1 + (2*it + 1)*D : 1 + 2*n*D;
    for (int i = 0; i < D; i++) exp_x[i*W +: W] = x[i][W-1:0];
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        A[(i*D+j)*W +: W] = Am[i][j][W-1:0];
        M[(i*D+j)*W +: W] = Mm[i][j][W-1:0];
      end
      b[i*W +: W]  = bv[i][W-1:0];
      x0[i*W +: W] = x0v[i][W-1:0];
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the IDLE
  // cycle following done.
  task automatic run(input int n, input bit hold);
    model(n);
    pack_inputs();
    num_iter = IW'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      @(negedge clk);
      chk("busy", busy, c <= exp_cyc);
      chk("done", done, c == exp_cyc);
      if (c < exp_cyc) begin
        chk("x_final_held", x_final, prev_x);
        chk("converged_held", converged, prev_conv);
        chk("iter_used_held", iter_used, prev_it);
      end else begin
        chk("x_final", x_final, exp_x);
        chk("converged", converged, exp_conv);
        chk("iter_used", iter_used, exp_it);
      end
    end
    prev_x = exp_x; prev_conv = exp_conv; prev_it = exp_it;
  endtask

  task automatic set_diag(input int a, input int m, input int bb, input int xx);
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        Am[i][j] = (i == j) ? a : 0;
        Mm[i][j] = (i == j) ? m : 0;
      end
      bv[i] = bb; x0v[i] = xx;
    end
  endtask

  task automatic set_rand(input int lo, input int hi);
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        Am[i][j] = rs(lo, hi);
        Mm[i][j] = rs(lo, hi);
      end
      bv[i] = rs(-128, 127); x0v[i] = rs(-128, 127);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [D*W-1:0] v;
    prev_x = '0; prev_conv = 1'b0; prev_it = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_conv", converged, 0);
    chk("rst_iter", iter_used, 0);
    chk("rst_x", x_final, 0);
    rst = 1'b0;
    @(negedge clk);

    // Converges after one update.
    set_diag(16, 16, 32, 0);
    run(3, 1'b0);
    chk("model_t1_cyc", exp_cyc, 49);
    chk("model_t1_x", exp_x, {D{8'd32}});
    chk("model_t1_conv", exp_conv, 1);
    chk("model_t1_it", exp_it, 1);

    run(1, 1'b0);
    chk("model_t2_cyc", exp_cyc, 33);
    chk("model_t2_conv", exp_conv, 0);

    // Update of 508 saturates to 127.
    set_diag(16, 64, 127, 0);
    run(1, 1'b0);
    chk("model_t3_x", exp_x, {D{8'd127}});
    chk("model_t3_cyc", exp_cyc, 33);

    // Zero iterations returns x0 immediately.
    for (int i = 0; i < D; i++) x0v[i] = i;
    run(0, 1'b0);
    for (int i = 0; i < D; i++) v[i*W +: W] = 8'(i);
    chk("model_t4_x", exp_x, v);
    chk("model_t4_cyc", exp_cyc, 1);

    // Start held high: one solve at a time, then back-to-back restarts.
    set_rand(-128, 127);
    run(2, 1'b1);
    set_rand(-16, 16);
    run(2, 1'b1);
    run(1, 1'b0);

    // Reset during UPD of iteration 2, then re-run the same problem.
    for (int k = 0; k < 20; k++) begin
      set_rand(-128, 127);
      model(3);
      if (exp_cyc == 97) break;
    end
    chk("model_noconv", exp_cyc, 97);
    pack_inputs();
    num_iter = IW'(3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      chk("pre_rst_done", done, 0);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_conv", converged, 0);
    chk("mid_rst_iter", iter_used, 0);
    chk("mid_rst_x", x_final, 0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_done", done, 0);
      chk("in_rst_busy", busy, 0);
    end
    rst = 1'b0;
    prev_x = '0; prev_conv = 1'b0; prev_it = 0;
    run(3, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_x_hold", x_final, prev_x);
    end

    // Randomised mix of problem shapes.
    for (int t = 0; t < 25; t++) begin
      case (t % 3)
        0: set_rand(-128, 127);
        1: begin
          set_diag(16, 16, 0, 0);
          for (int i = 0; i < D; i++) begin bv[i] = rs(-128, 127); x0v[i] = rs(-128, 127); end
        end
        default: begin
          set_rand(-6, 6);
          for (int i = 0; i < D; i++) begin Am[i][i] = rs(12, 20); Mm[i][i] = rs(12, 20); end
        end
      endcase
      run(rs(0, 4), 1'(t % 2));
    end
    start = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
